hazard_ctrl_pipe: RTL and testbench
===================================

Name: hazard_ctrl_pipe

Overview:
Consumes the decode-stage control bundle produced by the control unit and carries it through the E, M and W pipeline registers. Detects load-use and branch-operand hazards, drives forwarding selects, and generates stall and flush controls. It also freezes the pipeline while data memory is not ready and counts stall cycles. Sits beside the datapath in the 5-stage MiniSys1A core.

Parameters:
ALUCW, 4, width of alucontrol field
CNTW, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
regwriteD mem2regD memwriteD branchD jumpD alusrcD regdstD lwswD  in  1 each  D-stage control bits from the control unit
alucontrolD  in  ALUCW  D-stage ALU control
rsD rtD rdD  in  5 each  D-stage register fields
eqD  in  1  branch comparator result, after D forwarding
mem_readyM  in  1  data memory completes the M access this cycle
regwriteE mem2regE memwriteE alusrcE regdstE lwswE  out  1 each  E-stage controls
alucontrolE  out  ALUCW  E-stage ALU control
rsE rtE  out  5 each  E-stage source registers
regwriteM mem2regM memwriteM lwswM  out  1 each  M-stage controls
regwriteW mem2regW  out  1 each  W-stage controls
writeregE writeregM writeregW  out  5 each  destination register per stage
stallF stallD flushD flushE  out  1 each  pipeline control
pcsrcD  out  1  branch/jump redirect
forwardAD forwardBD  out  1 each  D-stage forward from M
forwardAE forwardBE  out  2 each  00 regfile, 01 from W, 10 from M
stall_cnt  out  CNTW  stall-cycle count

Behaviour:
- Reset (async, rst=1): all E/M/W registers and stall_cnt go to 0. All registered outputs read 0 immediately. Combinational outputs follow from the zeroed registers.
- writeregE = regdstE ? rdE : rtE. This value is combinational and is registered into writeregM, then writeregW.
- Stage advance is one cycle per stage. D→E captures all D controls plus rsD, rtD and rdD. E→M captures regwrite, mem2reg, memwrite, lwsw and writereg. M→W captures regwrite, mem2reg and writereg.
- lwstall is high when all hold: mem2regE, regwriteE, writeregE≠0, and writeregE equals rsD or rtD.
- branchstall is high when branchD is set and either condition holds:
  - regwriteE, writeregE≠0, and writeregE ∈ {rsD, rtD};
  - mem2regM, writeregM≠0, and writeregM ∈ {rsD, rtD}.
- memwait = (mem2regM | memwriteM) & ~mem_readyM.
- hazard = lwstall | branchstall.
- Priority is memwait over hazard.
  - memwait=1: stallF=stallD=1. The E and M registers hold. The W register loads a bubble (all controls 0, writereg 0). flushE=0, flushD=0.
  - Else hazard=1: stallF=stallD=1 and flushE=1. The E register loads a bubble (all E controls, rsE, rtE and rdE cleared). M and W advance.
  - Else: all stages advance and stalls are 0.
- pcsrcD = (branchD & eqD) | jumpD.
- flushD = pcsrcD & ~stallD. It is combinational; the D register lives in the datapath.
- forwardAD = regwriteM & writeregM≠0 & writeregM==rsD. forwardBD is the same with rtD.
- forwardAE:
  - 10 if regwriteM, writeregM≠0 and writeregM==rsE;
  - else 01 if regwriteW, writeregW≠0 and writeregW==rsE;
  - else 00.
  - M has priority over W. forwardBE is the same with rtE.
- Register $0 is never a hazard or forward source.
- stall_cnt increments on each clock where stallD=1. It saturates at all-ones and does not wrap.
- Simultaneous flush and stall: flushD is suppressed while stalled. The redirect is re-evaluated on the cycle the stall drops.
- If reset is asserted mid-memwait, the frozen state is discarded. After release the pipeline is empty.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles with random D inputs, then release with all D inputs 0. Expect every output 0, stall_cnt=0, and forward selects 00 for 5 cycles.
- Load-use: cycle0 lw with rt=8 (mem2regD=1, regwriteD=1, regdstD=0); cycle1 add with rsD=8. Expect stallF=stallD=flushE=1 for exactly 1 cycle and a bubble in E. In the next cycle forwardAE=01 (producer now in W) and stall_cnt=1.
- EX forwarding: back-to-back R-type with rd=5, then rs=5, rt=5. Expect forwardAE=forwardBE=10 in the consumer's E cycle. With one independent instruction between them, expect 01.
- Branch hazard: add rd=3, then beq rs=3, eqD=1. Expect branchstall for 1 cycle. Next cycle forwardAD=1, pcsrcD=1, flushD=1.
- Memory wait: sw in M with mem_readyM=0 for 3 cycles. Expect the E/M registers unchanged, regwriteW=0 during the wait, and stall_cnt +3. The sw leaves M on the cycle after mem_readyM=1.
- Saturation and $0: preload the counter near max by forcing a long memwait and confirm it holds at all-ones. Use writereg=0 with rsD=0 and expect no stall and no forward.

Source files
------------

// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe
// ----------------------------------------------------------------------------
// Pipeline control for the 5-stage MiniSys1A core. Carries the decode-stage
// control bundle through the E, M and W pipeline registers, detects load-use
// and branch-operand hazards, drives the D/E forwarding selects, and produces
// the fetch/decode stall and flush controls. A data-memory access that is not
// ready freezes the E and M stages. Stall cycles are counted in a saturating
// counter.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   *D control bits          decode-stage controls from the control unit
//   alucontrolD              decode-stage ALU control (ALUCW bits)
//   rsD, rtD, rdD            decode-stage register fields
//   eqD                      branch comparator result (already forwarded in D)
//   mem_readyM               data memory completes the M access this cycle
//   *E / *M / *W             registered controls per stage
//   writeregE/M/W            destination register per stage
//   stallF, stallD           hold the PC and the D register
//   flushD, flushE           clear the D register / load a bubble into E
//   pcsrcD                   branch taken or jump: redirect fetch
//   forwardAD, forwardBD     D-stage comparator operand forward from M
//   forwardAE, forwardBE     E-stage ALU operand select (00 rf, 01 W, 10 M)
//   stall_cnt                saturating count of cycles with stallD high
// ----------------------------------------------------------------------------
module hazard_ctrl_pipe #(
   parameter int unsigned ALUCW = 4,
   parameter int unsigned CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             regwriteD,
   input  logic             mem2regD,
   input  logic             memwriteD,
   input  logic             branchD,
   input  logic             jumpD,
   input  logic             alusrcD,
   input  logic             regdstD,
   input  logic             lwswD,
   input  logic [ALUCW-1:0] alucontrolD,
   input  logic [4:0]       rsD,
   input  logic [4:0]       rtD,
   input  logic [4:0]       rdD,
   input  logic             eqD,
   input  logic             mem_readyM,

   output logic             regwriteE,
   output logic             mem2regE,
   output logic             memwriteE,
   output logic             alusrcE,
   output logic             regdstE,
   output logic             lwswE,
   output logic [ALUCW-1:0] alucontrolE,
   output logic [4:0]       rsE,
   output logic [4:0]       rtE,

   output logic             regwriteM,
   output logic             mem2regM,
   output logic             memwriteM,
   output logic             lwswM,

   output logic             regwriteW,
   output logic             mem2regW,

   output logic [4:0]       writeregE,
   output logic [4:0]       writeregM,
   output logic [4:0]       writeregW,

   output logic             stallF,
   output logic             stallD,
   output logic             flushD,
   output logic             flushE,
   output logic             pcsrcD,
   output logic             forwardAD,
   output logic             forwardBD,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic [CNTW-1:0]  stall_cnt
);

   // ------------------------------------------------------------------------
   // Pipeline register contents
   // ------------------------------------------------------------------------
   typedef struct packed {
      logic             regwrite;
      logic             mem2reg;
      logic             memwrite;
      logic             alusrc;
      logic             regdst;
      logic             lwsw;
      logic [ALUCW-1:0] alucontrol;
      logic [4:0]       rs;
      logic [4:0]       rt;
      logic [4:0]       rd;
   } e_stage_t;

   typedef struct packed {
      logic       regwrite;
      logic       mem2reg;
      logic       memwrite;
      logic       lwsw;
      logic [4:0] writereg;
   } m_stage_t;

   typedef struct packed {
      logic       regwrite;
      logic       mem2reg;
      logic [4:0] writereg;
   } w_stage_t;

   e_stage_t        e_q, e_d;
   m_stage_t        m_q, m_d;
   w_stage_t        w_q, w_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

   // ------------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------------
   logic [4:0] writereg_e;
   logic       we_nz;
   logic       wm_nz;
   logic       ww_nz;
   logic       e_hits_d;
   logic       m_hits_d;
   logic       lwstall;
   logic       branchstall;
   logic       memwait;
   logic       hazard;
   logic       stall;
   logic       pcsrc;

   always_comb begin
      writereg_e  = e_q.regdst ? e_q.rd : e_q.rt;
      // $0 is hard-wired zero, so it never produces a hazard or a forward.
      we_nz       = (writereg_e != 5'd0);
      wm_nz       = (m_q.writereg != 5'd0);
      ww_nz       = (w_q.writereg != 5'd0);
      e_hits_d    = we_nz & ((writereg_e == rsD) | (writereg_e == rtD));
      m_hits_d    = wm_nz & ((m_q.writereg == rsD) | (m_q.writereg == rtD));

      lwstall     = e_q.mem2reg & e_q.regwrite & e_hits_d;
      // The branch comparator sits in D, so any ALU result still in E, or
      // load data still in M, cannot reach it in time.
      branchstall = branchD & ((e_q.regwrite & e_hits_d) | (m_q.mem2reg & m_hits_d));
      memwait     = (m_q.mem2reg | m_q.memwrite) & ~mem_readyM;
      hazard      = lwstall | branchstall;
      stall       = memwait | hazard;
      pcsrc       = (branchD & eqD) | jumpD;
   end

   assign stallF = stall;
   assign stallD = stall;
   // A frozen pipeline must not also be flushed into a bubble in E.
   assign flushE = hazard & ~memwait;
   // The redirect is dropped while stalled and re-evaluated once D moves.
   assign flushD = pcsrc & ~stall;
   assign pcsrcD = pcsrc;

   // ------------------------------------------------------------------------
   // Forwarding selects
   // ------------------------------------------------------------------------
   always_comb begin
      forwardAD = m_q.regwrite & wm_nz & (m_q.writereg == rsD);
      forwardBD = m_q.regwrite & wm_nz & (m_q.writereg == rtD);

      // M holds the younger result, so it wins over W.
      forwardAE = 2'b00;
      if (m_q.regwrite && wm_nz && (m_q.writereg == e_q.rs)) begin
         forwardAE = 2'b10;
      end else if (w_q.regwrite && ww_nz && (w_q.writereg == e_q.rs)) begin
         forwardAE = 2'b01;
      end

      forwardBE = 2'b00;
      if (m_q.regwrite && wm_nz && (m_q.writereg == e_q.rt)) begin
         forwardBE = 2'b10;
      end else if (w_q.regwrite && ww_nz && (w_q.writereg == e_q.rt)) begin
         forwardBE = 2'b01;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state for the stage registers and the stall counter
   // ------------------------------------------------------------------------
   always_comb begin
      e_d   = e_q;
      m_d   = m_q;
      w_d   = w_q;
      cnt_d = cnt_q;

      if (memwait) begin
         // E and M hold; the M access has not retired, so W sees a bubble.
         w_d = '0;
      end else begin
         if (hazard) begin
            e_d = '0;
         end else begin
            e_d.regwrite   = regwriteD;
            e_d.mem2reg    = mem2regD;
            e_d.memwrite   = memwriteD;
            e_d.alusrc     = alusrcD;
            e_d.regdst     = regdstD;
            e_d.lwsw       = lwswD;
            e_d.alucontrol = alucontrolD;
            e_d.rs         = rsD;
            e_d.rt         = rtD;
            e_d.rd         = rdD;
         end

         m_d.regwrite = e_q.regwrite;
         m_d.mem2reg  = e_q.mem2reg;
         m_d.memwrite = e_q.memwrite;
         m_d.lwsw     = e_q.lwsw;
         m_d.writereg = writereg_e;

         w_d.regwrite = m_q.regwrite;
         w_d.mem2reg  = m_q.mem2reg;
         w_d.writereg = m_q.writereg;
      end

      if (stall && (cnt_q != {CNTW{1'b1}})) begin
         cnt_d = cnt_q + CNTW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q   <= '0;
         m_q   <= '0;
         w_q   <= '0;
         cnt_q <= '0;
      end else begin
         e_q   <= e_d;
         m_q   <= m_d;
         w_q   <= w_d;
         cnt_q <= cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Registered outputs
   // ------------------------------------------------------------------------
   assign regwriteE   = e_q.regwrite;
   assign mem2regE    = e_q.mem2reg;
   assign memwriteE   = e_q.memwrite;
   assign alusrcE     = e_q.alusrc;
   assign regdstE     = e_q.regdst;
   assign lwswE       = e_q.lwsw;
   assign alucontrolE = e_q.alucontrol;
   assign rsE         = e_q.rs;
   assign rtE         = e_q.rt;

   assign regwriteM   = m_q.regwrite;
   assign mem2regM    = m_q.mem2reg;
   assign memwriteM   = m_q.memwrite;
   assign lwswM       = m_q.lwsw;

   assign regwriteW   = w_q.regwrite;
   assign mem2regW    = w_q.mem2reg;

   assign writeregE   = writereg_e;
   assign writeregM   = m_q.writereg;
   assign writeregW   = w_q.writereg;

   assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// tb_hazard_ctrl_pipe
// Directed bench for hazard_ctrl_pipe. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 unit later, well away from the edge.
// The counter is built 8 bits wide so saturation is reached quickly.
module tb_hazard_ctrl_pipe;

   localparam int unsigned ALUCW = 4;
   localparam int unsigned CNTW  = 8;

   logic             clk;
   logic             rst;
   logic             regwriteD, mem2regD, memwriteD, branchD, jumpD;
   logic             alusrcD, regdstD, lwswD;
   logic [ALUCW-1:0] alucontrolD;
   logic [4:0]       rsD, rtD, rdD;
   logic             eqD;
   logic             mem_readyM;

   logic             regwriteE, mem2regE, memwriteE, alusrcE, regdstE, lwswE;
   logic [ALUCW-1:0] alucontrolE;
   logic [4:0]       rsE, rtE;
   logic             regwriteM, mem2regM, memwriteM, lwswM;
   logic             regwriteW, mem2regW;
   logic [4:0]       writeregE, writeregM, writeregW;
   logic             stallF, stallD, flushD, flushE, pcsrcD;
   logic             forwardAD, forwardBD;
   logic [1:0]       forwardAE, forwardBE;
   logic [CNTW-1:0]  stall_cnt;

   int chk_cnt;
   int pass_cnt;

   logic reg_any;
   logic all_any;

   hazard_ctrl_pipe #(
      .ALUCW (ALUCW),
      .CNTW  (CNTW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .regwriteD   (regwriteD),
      .mem2regD    (mem2regD),
      .memwriteD   (memwriteD),
      .branchD     (branchD),
      .jumpD       (jumpD),
      .alusrcD     (alusrcD),
      .regdstD     (regdstD),
      .lwswD       (lwswD),
      .alucontrolD (alucontrolD),
      .rsD         (rsD),
      .rtD         (rtD),
      .rdD         (rdD),
      .eqD         (eqD),
      .mem_readyM  (mem_readyM),
      .regwriteE   (regwriteE),
      .mem2regE    (mem2regE),
      .memwriteE   (memwriteE),
      .alusrcE     (alusrcE),
      .regdstE     (regdstE),
      .lwswE       (lwswE),
      .alucontrolE (alucontrolE),
      .rsE         (rsE),
      .rtE         (rtE),
      .regwriteM   (regwriteM),
      .mem2regM    (mem2regM),
      .memwriteM   (memwriteM),
      .lwswM       (lwswM),
      .regwriteW   (regwriteW),
      .mem2regW    (mem2regW),
      .writeregE   (writeregE),
      .writeregM   (writeregM),
      .writeregW   (writeregW),
      .stallF      (stallF),
      .stallD      (stallD),
      .flushD      (flushD),
      .flushE      (flushE),
      .pcsrcD      (pcsrcD),
      .forwardAD   (forwardAD),
      .forwardBD   (forwardBD),
      .forwardAE   (forwardAE),
      .forwardBE   (forwardBE),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // OR of every registered output, and of every output.
   assign reg_any = |{regwriteE, mem2regE, memwriteE, alusrcE, regdstE, lwswE, alucontrolE,
                      rsE, rtE, regwriteM, mem2regM, memwriteM, lwswM, regwriteW, mem2regW,
                      writeregE, writeregM, writeregW, stall_cnt};
   assign all_any = reg_any | (|{stallF, stallD, flushD, flushE, pcsrcD, forwardAD, forwardBD,
                                 forwardAE, forwardBE});

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_d();
      regwriteD = 0; mem2regD = 0; memwriteD = 0; branchD = 0; jumpD = 0;
      alusrcD = 0; regdstD = 0; lwswD = 0; alucontrolD = '0;
      rsD = '0; rtD = '0; rdD = '0; eqD = 0;
   endtask

   // R-type: rd <= rs op rt
   task automatic set_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      clear_d();
      regwriteD = 1; regdstD = 1; alucontrolD = 4'h2;
      rsD = rs; rtD = rt; rdD = rd;
   endtask

   // Load: rt <= mem[rs + imm]
   task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
      clear_d();
      regwriteD = 1; mem2regD = 1; alusrcD = 1;
      rsD = rs; rtD = rt;
   endtask

   task automatic do_reset();
      clear_d();
      mem_readyM = 1;
      rst = 1;
      #1;
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      mem_readyM = 1'($urandom_range(0, 1));
      for (int i = 0; i < 2; i++) begin
         regwriteD = 1'($urandom_range(0, 1)); mem2regD = 1'($urandom_range(0, 1));
         memwriteD = 1'($urandom_range(0, 1)); branchD = 1'($urandom_range(0, 1));
         jumpD = 1'($urandom_range(0, 1)); alusrcD = 1'($urandom_range(0, 1));
         regdstD = 1'($urandom_range(0, 1)); lwswD = 1'($urandom_range(0, 1));
         alucontrolD = 4'($urandom_range(0, 15)); eqD = 1'($urandom_range(0, 1));
         rsD = 5'($urandom_range(0, 31)); rtD = 5'($urandom_range(0, 31));
         rdD = 5'($urandom_range(0, 31));
         tick();
         chk_cnt++;
         if (reg_any !== 1'b0) $display("FAIL reset_regs[%0d]: got any=%b want 0", i, reg_any);
         else pass_cnt++;
      end
      clear_d();
      mem_readyM = 1;
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk_cnt++;
         if (all_any !== 1'b0 || forwardAE !== 2'b00 || forwardBE !== 2'b00 || stall_cnt !== '0)
            $display("FAIL reset_idle[%0d]: got any=%b fAE=%b fBE=%b cnt=%0d want 0",
                     i, all_any, forwardAE, forwardBE, stall_cnt);
         else pass_cnt++;
         tick();
      end
   endtask

   task automatic test_load_use();
      do_reset();
      set_lw(5'd1, 5'd8);
      #1;
      chk_cnt++;
      if (stallD !== 1'b0) $display("FAIL lu_no_stall_first: got %b want 0", stallD);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (writeregE !== 5'd8) $display("FAIL lu_writeregE: got %0d want 8", writeregE);
      else pass_cnt++;

      set_rtype(5'd8, 5'd2, 5'd9);
      #1;
      chk_cnt++;
      if ({stallF, stallD, flushE} !== 3'b111 || stall_cnt !== 8'd0)
         $display("FAIL lu_stall: got sF/sD/fE=%b cnt=%0d want 111 cnt=0",
                  {stallF, stallD, flushE}, stall_cnt);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({regwriteE, mem2regE, rsE, rtE, writeregE} !== '0)
         $display("FAIL lu_bubble: got rwE=%b m2rE=%b rsE=%0d rtE=%0d want 0",
                  regwriteE, mem2regE, rsE, rtE);
      else pass_cnt++;
      chk_cnt++;
      if ({regwriteM, mem2regM, writeregM} !== {1'b1, 1'b1, 5'd8} || stall_cnt !== 8'd1)
         $display("FAIL lu_m_stage: got rwM=%b m2rM=%b wrM=%0d cnt=%0d want 1 1 8 cnt=1",
                  regwriteM, mem2regM, writeregM, stall_cnt);
      else pass_cnt++;
      // Consumer is still in D; the stall lasts exactly one cycle.
      #1;
      chk_cnt++;
      if ({stallF, stallD, flushE} !== 3'b000)
         $display("FAIL lu_stall_once: got %b want 000", {stallF, stallD, flushE});
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (forwardAE !== 2'b01 || forwardBE !== 2'b00 || rsE !== 5'd8 || stall_cnt !== 8'd1)
         $display("FAIL lu_fwd_w: got fAE=%b fBE=%b rsE=%0d cnt=%0d want 01 00 8 1",
                  forwardAE, forwardBE, rsE, stall_cnt);
      else pass_cnt++;
      clear_d();
   endtask

   task automatic test_ex_forward();
      // Back-to-back: producer in M when consumer in E.
      do_reset();
      set_rtype(5'd1, 5'd2, 5'd5);
      tick();
      set_rtype(5'd5, 5'd5, 5'd6);
      #1;
      chk_cnt++;
      if (stallD !== 1'b0) $display("FAIL exf_no_stall: got %b want 0", stallD);
      else pass_cnt++;
      tick();
      clear_d();
      #1;
      chk_cnt++;
      if (forwardAE !== 2'b10 || forwardBE !== 2'b10)
         $display("FAIL exf_from_m: got fAE=%b fBE=%b want 10 10", forwardAE, forwardBE);
      else pass_cnt++;

      // One independent instruction between: producer in W.
      do_reset();
      set_rtype(5'd1, 5'd2, 5'd5);
      tick();
      set_rtype(5'd1, 5'd2, 5'd7);
      tick();
      set_rtype(5'd5, 5'd5, 5'd6);
      tick();
      clear_d();
      #1;
      chk_cnt++;
      if (forwardAE !== 2'b01 || forwardBE !== 2'b01)
         $display("FAIL exf_from_w: got fAE=%b fBE=%b want 01 01", forwardAE, forwardBE);
      else pass_cnt++;

      // Two producers of r5: the younger one in M must win.
      do_reset();
      set_rtype(5'd1, 5'd2, 5'd5);
      tick();
      set_rtype(5'd3, 5'd4, 5'd5);
      tick();
      set_rtype(5'd5, 5'd9, 5'd6);
      tick();
      clear_d();
      #1;
      chk_cnt++;
      if (forwardAE !== 2'b10 || forwardBE !== 2'b00)
         $display("FAIL exf_m_priority: got fAE=%b fBE=%b want 10 00", forwardAE, forwardBE);
      else pass_cnt++;
   endtask

   task automatic test_branch();
      do_reset();
      set_rtype(5'd1, 5'd2, 5'd3);
      tick();
      clear_d();
      branchD = 1; eqD = 1; rsD = 5'd3; rtD = 5'd4;
      #1;
      chk_cnt++;
      if ({stallF, stallD, flushE} !== 3'b111 || pcsrcD !== 1'b1 || flushD !== 1'b0)
         $display("FAIL br_stall: got sF/sD/fE=%b pcsrc=%b flushD=%b want 111 1 0",
                  {stallF, stallD, flushE}, pcsrcD, flushD);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (stallD !== 1'b0 || forwardAD !== 1'b1 || forwardBD !== 1'b0 || pcsrcD !== 1'b1 ||
          flushD !== 1'b1 || regwriteE !== 1'b0 || stall_cnt !== 8'd1)
         $display("FAIL br_resolve: got sD=%b fAD=%b fBD=%b pcsrc=%b flushD=%b rwE=%b cnt=%0d want 0 1 0 1 1 0 1",
                  stallD, forwardAD, forwardBD, pcsrcD, flushD, regwriteE, stall_cnt);
      else pass_cnt++;
      tick();
      clear_d();
   endtask

   task automatic test_mem_wait();
      do_reset();
      set_rtype(5'd1, 5'd2, 5'd10);
      tick();
      clear_d();
      memwriteD = 1; alusrcD = 1; rsD = 5'd1; rtD = 5'd6;
      tick();
      set_rtype(5'd12, 5'd13, 5'd11);
      tick();
      // E=add r11, M=sw, W=add r10. A pending jump in D must not flush.
      clear_d();
      jumpD = 1;
      mem_readyM = 0;
      #1;
      chk_cnt++;
      if ({stallF, stallD} !== 2'b11 || flushE !== 1'b0 || flushD !== 1'b0 || pcsrcD !== 1'b1)
         $display("FAIL mw_freeze: got sF/sD=%b fE=%b fD=%b pcsrc=%b want 11 0 0 1",
                  {stallF, stallD}, flushE, flushD, pcsrcD);
      else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_cnt++;
         if (memwriteM !== 1'b1 || writeregM !== 5'd6 || regwriteE !== 1'b1 ||
             writeregE !== 5'd11 || rsE !== 5'd12 || regwriteW !== 1'b0 ||
             stall_cnt !== 8'(k + 1))
            $display("FAIL mw_hold[%0d]: got mwM=%b wrM=%0d rwE=%b wrE=%0d rsE=%0d rwW=%b cnt=%0d want 1 6 1 11 12 0 %0d",
                     k, memwriteM, writeregM, regwriteE, writeregE, rsE, regwriteW, stall_cnt,
                     k + 1);
         else pass_cnt++;
      end
      mem_readyM = 1;
      #1;
      chk_cnt++;
      if (stallD !== 1'b0 || flushD !== 1'b1)
         $display("FAIL mw_release: got sD=%b flushD=%b want 0 1", stallD, flushD);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (memwriteM !== 1'b0 || regwriteM !== 1'b1 || writeregM !== 5'd11 ||
          stall_cnt !== 8'd3)
         $display("FAIL mw_advance: got mwM=%b rwM=%b wrM=%0d cnt=%0d want 0 1 11 3",
                  memwriteM, regwriteM, writeregM, stall_cnt);
      else pass_cnt++;
      clear_d();
   endtask

   task automatic test_saturation_zero();
      do_reset();
      set_lw(5'd1, 5'd8);
      tick();
      clear_d();
      tick();
      mem_readyM = 0;
      repeat (254) tick();
      chk_cnt++;
      if (stall_cnt !== 8'd254) $display("FAIL sat_pre: got %0d want 254", stall_cnt);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (stall_cnt !== 8'd255) $display("FAIL sat_max: got %0d want 255", stall_cnt);
      else pass_cnt++;
      repeat (5) tick();
      chk_cnt++;
      if (stall_cnt !== 8'd255 || stallD !== 1'b1)
         $display("FAIL sat_hold: got cnt=%0d sD=%b want 255 1", stall_cnt, stallD);
      else pass_cnt++;

      // Reset in the middle of the wait discards the frozen load.
      rst = 1;
      #1;
      chk_cnt++;
      if (reg_any !== 1'b0) $display("FAIL mw_reset: got any=%b want 0", reg_any);
      else pass_cnt++;
      rst = 0;
      tick();
      chk_cnt++;
      if (reg_any !== 1'b0 || stallD !== 1'b0)
         $display("FAIL mw_reset_empty: got any=%b sD=%b want 0 0", reg_any, stallD);
      else pass_cnt++;
      mem_readyM = 1;

      // $0 as destination: never a hazard, never forwarded.
      do_reset();
      set_lw(5'd1, 5'd0);
      tick();
      clear_d();
      branchD = 1; rsD = 5'd0; rtD = 5'd0;
      #1;
      chk_cnt++;
      if (stallD !== 1'b0 || flushE !== 1'b0)
         $display("FAIL zero_no_stall: got sD=%b fE=%b want 0 0", stallD, flushE);
      else pass_cnt++;
      tick();
      set_rtype(5'd0, 5'd0, 5'd0);
      #1;
      chk_cnt++;
      if (stallD !== 1'b0 || forwardAD !== 1'b0 || forwardBD !== 1'b0)
         $display("FAIL zero_no_fwd_d: got sD=%b fAD=%b fBD=%b want 0 0 0",
                  stallD, forwardAD, forwardBD);
      else pass_cnt++;
      tick();
      clear_d();
      #1;
      chk_cnt++;
      if (forwardAE !== 2'b00 || forwardBE !== 2'b00 || regwriteW !== 1'b1)
         $display("FAIL zero_no_fwd_e: got fAE=%b fBE=%b rwW=%b want 00 00 1",
                  forwardAE, forwardBE, regwriteW);
      else pass_cnt++;
   endtask

   initial begin
      chk_cnt  = 0;
      pass_cnt = 0;
      clear_d();
      mem_readyM = 1;
      test_reset();
      test_load_use();
      test_ex_forward();
      test_branch();
      test_mem_wait();
      test_saturation_zero();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
